// File: rtl/led_decoder_scan_pkg.sv
// Shared definitions for the LED decoder: mode encodings, state type and
// the index-to-one-hot decode used by the output register.
package led_pkg;

  localparam logic [1:0] MODE_OFF       = 2'b00;
  localparam logic [1:0] MODE_DIRECT    = 2'b01;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b10;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF       = MODE_OFF,
    ST_DIRECT    = MODE_DIRECT,
    ST_SCAN_UP   = MODE_SCAN_UP,
    ST_SCAN_DOWN = MODE_SCAN_DOWN
  } state_t;

  // Index 0 maps to bit width-1 (the MSB of the LED bank); result sits in
  // the low 'width' bits and is inverted for an active-low bank.
  function automatic logic [63:0] decode(input int index, input int width,
                                         input logic active_low);
    logic [63:0] v;
    logic [5:0]  pos;
    v      = '0;
    pos    = 6'(width - 1 - index);
    v[pos] = 1'b1;
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/led_decoder_scan_sw_debounce.sv
// Two-flop synchroniser followed by a consecutive-stable-cycle debouncer;
// dout only moves after DEB_CYCLES unchanged samples.
module sw_debounce #(
  parameter int W          = 3,
  parameter int DEB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int               CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
      dout  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        dout <= cand;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/led_decoder_scan.sv
// One-hot LED decoder with debounced switch select, selectable polarity and
// an up/down chaser mode. led and idx are both registered.
//
//   state        | meaning
//   ST_OFF       | all LEDs dark, idx frozen
//   ST_DIRECT    | idx follows the debounced switch value
//   ST_SCAN_UP   | idx increments every SCAN_DIV cycles, wraps naturally
//   ST_SCAN_DOWN | idx decrements every SCAN_DIV cycles, wraps naturally
module led_decoder_scan
  import led_pkg::*;
#(
  parameter int   SEL_W      = 3,
  localparam int  OUT_W      = 1 << SEL_W,
  parameter bit   ACTIVE_LOW = 1'b1,
  parameter int   DEB_CYCLES = 16,
  parameter int   SCAN_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sw,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] led,
  output logic [SEL_W-1:0] idx
);

  localparam int               DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);
  localparam logic [OUT_W-1:0] LED_OFF = {OUT_W{ACTIVE_LOW}};

  state_t           state;
  logic             scan_run;
  logic [DIV_W-1:0] div_cnt;
  logic [SEL_W-1:0] sw_stable;
  logic [SEL_W-1:0] idx_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic [OUT_W-1:0] dec_nxt;

  sw_debounce #(
    .W          (SEL_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sw),
    .dout  (sw_stable)
  );

  // scan_run is low on the first scan cycle after OFF/DIRECT, which triggers
  // the reload; an UP<->DOWN swap keeps it high so idx and div carry over.
  always_comb begin
    idx_nxt = idx;
    div_nxt = div_cnt;
    case (state)
      ST_OFF: begin
      end
      ST_DIRECT: idx_nxt = sw_stable;
      default: begin
        if (!scan_run) begin
          idx_nxt = sw_stable;
          div_nxt = '0;
        end else if (div_cnt == DIV_MAX) begin
          div_nxt = '0;
          idx_nxt = (state == ST_SCAN_UP) ? idx + IDX_ONE : idx - IDX_ONE;
        end else begin
          div_nxt = div_cnt + DIV_ONE;
        end
      end
    endcase
    dec_nxt = OUT_W'(decode(int'(idx_nxt), OUT_W, ACTIVE_LOW));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_OFF;
      scan_run <= 1'b0;
      div_cnt  <= '0;
      idx      <= '0;
      led      <= LED_OFF;
    end else begin
      state    <= state_t'(mode);
      scan_run <= (state == ST_SCAN_UP) || (state == ST_SCAN_DOWN);
      div_cnt  <= div_nxt;
      idx      <= idx_nxt;
      led      <= (state == ST_OFF) ? LED_OFF : dec_nxt;
    end
  end

endmodule

// File: doc/led_decoder_scan.md
Name: led_decoder_scan

Overview:
- Parametrised N-to-2^N one-hot LED decoder. It adds switch synchronisation and debounce, a registered output, selectable output polarity, and an auto-scan mode (chaser, up or down).
- Sits between board switches and the LED bank in the lab top level.
- Drives an active-low LED bank when ACTIVE_LOW=1.

Parameters:
SEL_W, 3, select width; legal range 1..6.
OUT_W, 2**SEL_W, LED count; derived, must not be overridden.
ACTIVE_LOW, 1, 1: selected LED = 0 and others = 1; 0: inverted.
DEB_CYCLES, 16, consecutive stable cycles required to accept a switch value; >=1.
SCAN_DIV, 4, clock cycles per scan step; >=1.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  synchronous, active-low reset.
sw  in  SEL_W  raw asynchronous switch select.
mode  in  2  00 OFF, 01 DIRECT, 10 SCAN_UP, 11 SCAN_DOWN.
led  out  OUT_W  registered one-hot (per polarity) LED drive.
idx  out  SEL_W  registered index currently lit.

Behaviour:
- Reset (rst_n=0 at an edge):
  - led = all-off (all 1s if ACTIVE_LOW, else all 0s); idx=0.
  - Sync flops=0; candidate=0; deb count=0; sw_stable=0; div count=0; state OFF.
  - Reset wins over every other event in that cycle, including mid-scan and mid-debounce.
- Mapping: index k lights led[OUT_W-1-k], so index 0 lights the MSB. With SEL_W=3, ACTIVE_LOW=1: idx 0 -> 8'b0111_1111, idx 7 -> 8'b1111_1110.
- Synchroniser: 2-flop on sw, giving sw_sync.
- Debounce, per edge:
  - If sw_sync != candidate: candidate <= sw_sync, count <= 0.
  - Else if count == DEB_CYCLES-1: sw_stable <= candidate.
  - Else: count++.
  - Count saturates at DEB_CYCLES-1 while stable.
- Latency: a clean sw change before edge 1 reaches sw_stable at edge DEB_CYCLES+3 and reaches led/idx at edge DEB_CYCLES+4. A sw pulse shorter than DEB_CYCLES cycles never changes sw_stable.
- State is mode registered each cycle; a mode change takes effect in led one cycle after it is sampled.
- OFF: led = all-off; idx holds its last value.
- DIRECT: idx <= sw_stable; led <= decode(sw_stable) each cycle.
- Entering SCAN_UP or SCAN_DOWN from OFF or DIRECT:
  - idx loads sw_stable and div count clears.
  - First step occurs SCAN_DIV cycles later.
- SCAN_UP: when div count == SCAN_DIV-1, div <= 0 and idx <= idx+1 mod OUT_W (OUT_W-1 wraps to 0); otherwise div++.
- SCAN_DOWN: same, with idx-1; 0 wraps to OUT_W-1.
- Switching SCAN_UP <-> SCAN_DOWN directly: idx and div are kept and direction reverses; there is no reload.
- SCAN_DIV=1: idx steps every cycle.
- sw changes during scan update sw_stable but do not move idx.
- In all non-OFF states led = decode(idx) with exactly one active bit. led is never all-active and never multi-hot.
- Arithmetic is modulo 2^SEL_W, so wrap is natural and needs no compare.

Decomposition:
- Shared package led_pkg holds:
  - mode encodings MODE_OFF=2'b00, MODE_DIRECT=2'b01, MODE_SCAN_UP=2'b10, MODE_SCAN_DOWN=2'b11;
  - a decode function (index, width, polarity) -> one-hot vector.
- Sub-module sw_debounce (parameters W, DEB_CYCLES; ports clk, rst_n, din, dout) contains the synchroniser and debounce. It is instantiated once, W=SEL_W.
- Top-level module holds the state register, div counter, idx and the output register.

Test Plan:
(Bench overrides: SEL_W=3, DEB_CYCLES=4, SCAN_DIV=2, ACTIVE_LOW=1.)
1. Reset: rst_n=0 for 2 edges with mode=01, sw=3'b101 -> led=8'hFF, idx=0. Release with sw held -> led=8'b1111_1011, idx=5 at edge 8 after release, not earlier.
2. DIRECT sweep: sw 0..7, each held 10 cycles -> led walks 0111_1111, 1011_1111, ... 1111_1110, one-hot-low each time.
3. Bounce: in DIRECT with stable sw=2, sw glitches to 6 for 3 cycles then back to 2 -> led stays 1101_1111 throughout.
4. SCAN_UP: sw_stable=6, mode 01->10 -> idx 6,6,7,7,0,0,1 on consecutive cycles after entry. Wrap 7->0 gives led 1111_1110 -> 0111_1111.
5. SCAN_DOWN and reversal: SCAN_DOWN from sw_stable=1 -> idx 1,1,0,0,7. Switch to SCAN_UP mid-period -> idx continues 7 then 0 with no reload.
6. OFF and reset mid-scan: mode=00 during scan -> led=8'hFF, idx frozen. rst_n=0 pulse during SCAN_UP -> next edge led=8'hFF, idx=0, state OFF regardless of mode.
